umul_nch: RTL and testbench
===========================

Name: umul_nch

Overview:
- Multi-channel unary (stochastic) multiplier. Successor to the single-channel unipolar multiplier.
- Each of NCH channels multiplies an incoming bitstream iA[ch] by a binary weight B[ch], loaded through loadB.
- Each channel has its own bit-reversed-counter (1-D Sobol) RNG. The product is emitted as a bitstream on oC[ch].
- Adds a compile-time bipolar mode and a per-channel load handshake. Sits between stochastic stream generators and downstream stochastic adders/accumulators.

Parameters:
- INWD, 8, weight and RNG width in bits (legal range 2..16).
- NCH, 4, number of independent channels.
- BIPOLAR, 0, 0 = unipolar AND-style multiply; 1 = bipolar XNOR-style multiply.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- iA  in  NCH  input bitstreams, bit ch belongs to channel ch.
- iB  in  NCH*INWD  weights, channel ch in bits [ch*INWD +: INWD].
- loadB  in  NCH  per-channel weight load strobe, bit ch.
- oC  out  NCH  product bitstreams, registered.

Behaviour:
- Reset: B_reg, cntP and cntN cleared for all channels; oC = 0.
  - Reset asserted mid-stream clears everything immediately (asynchronous).
  - The sequence restarts deterministically after release.
- Per-channel state:
  - B_reg: INWD bits.
  - cntP: INWD bits, counts iA=1 cycles.
  - cntN: INWD bits, used only when BIPOLAR=1.
  - rngP = bit-reverse(cntP); rngN = bit-reverse(cntN).
- Unipolar (BIPOLAR=0), at each edge:
  - oC[ch] <= iA[ch] & (B_reg > rngP).
  - cntP advances by 1 only when iA[ch]=1; it is frozen otherwise.
- Bipolar (BIPOLAR=1), at each edge:
  - If iA[ch]=1: oC[ch] <= (B_reg > rngP) and cntP advances.
  - Else: oC[ch] <= ~(B_reg > rngN) and cntN advances.
  - Weight encoding: B = 2^(INWD-1) represents 0.
- Latency: 1 cycle from iA to oC.
- Comparison is unsigned, strict greater-than.
  - B=0 never produces a 1.
  - B=2^INWD-1 produces 2^INWD-1 ones per 2^INWD advances.
- Counter wrap: cntP and cntN wrap from 2^INWD-1 to 0 silently. The RNG sequence is periodic with period 2^INWD advances.
- Load: loadB[ch]=1 at an edge does three things:
  - B_reg[ch] <= iB slice.
  - cntP[ch] and cntN[ch] <= 0.
  - oC[ch] for that edge is computed from the old B_reg and old counters.
- Load with iA=1 in the same cycle: the load wins; counters go to 0, not 0+1.
- Load is held for several cycles: counters are held at 0 each cycle; B_reg follows iB.
- Channels are fully independent; a load on one channel never disturbs another.
- X on iA or iB while the corresponding loadB is low has no effect on state.

Optional Feature:
- Macro: UMUL_ACC_EN.
- With the macro defined, two extra outputs are present:
  - oAcc (NCH*(INWD+1) bits): per-channel count of ones over a window.
  - oAccVld (1 bit): window-complete pulse.
- Window operation:
  - A global window counter of INWD bits increments every cycle after reset.
  - acc[ch] += oC[ch] every cycle.
  - At the edge where the window counter equals 2^INWD-1: oAcc[ch] <= acc[ch] + oC[ch] and acc[ch] <= 0.
  - oAccVld is high for exactly the following cycle.
- Reset clears the window counter, acc, oAcc and oAccVld. loadB does not affect the window.
- Without the macro, these ports and all related logic are absent; the core behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 with random iA/iB/loadB → oC=0; after release with iA=0 → oC stays 0.
- Unipolar, INWD=8: load B=128 on ch0, then iA[0]=1 for 256 cycles → oC[0] is 1,0,1,0… starting with 1, exactly 128 ones.
- Gapped input: B=64, iA[0] toggling 1/0 for 512 cycles → exactly 64 ones; oC=0 on every cycle following iA=0.
- Extremes: B=0 over 256 iA=1 cycles → 0 ones. B=255 → 255 ones, with the single 0 when cntP=255.
- Bipolar build: B=128 with iA=1 for 256 cycles → 128 ones. B=255 with iA=0 for 256 cycles → exactly 1 one.
- Concurrency and reset (UMUL_ACC_EN defined):
  - loadB[1] together with iA[1]=1 mid-stream → ch1 counters restart at 0; ch0 output unchanged.
  - Continuous B=128, iA=1 → oAcc[0]=128 on every window after the first, with oAccVld pulses spaced 256 cycles apart.
  - rst_n pulsed mid-window → all state cleared and the pattern restarts.

Source files
------------

// File: rtl/umul_nch.sv
// Multi-channel unary multiplier, bit-reversed counter RNG per channel.
// Define UMUL_ACC_EN to add the per-channel windowed ones accumulator.
module umul_nch #(
  parameter int INWD    = 8,
  parameter int NCH     = 4,
  parameter int BIPOLAR = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NCH-1:0]           iA,
  input  logic [NCH*INWD-1:0]      iB,
  input  logic [NCH-1:0]           loadB,
  output logic [NCH-1:0]           oC
`ifdef UMUL_ACC_EN
  ,
  output logic [NCH*(INWD+1)-1:0]  oAcc,
  output logic                     oAccVld
`endif
);

  function automatic logic [INWD-1:0] bitrev(
    input logic [INWD-1:0] v
  );
    logic [INWD-1:0] r;
    for (int i = 0; i < INWD; i++) begin
      r[i] = v[INWD-1-i];
    end
    return r;
  endfunction

`ifdef UMUL_ACC_EN
  logic [INWD-1:0] win_q;
  logic            win_last;

  assign win_last = (win_q == {INWD{1'b1}});

  // free-running window counter and end-of-window pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q   <= '0;
      oAccVld <= 1'b0;
    end else begin
      win_q   <= win_q + 1'b1;
      oAccVld <= win_last;
    end
  end
`endif

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    logic [INWD-1:0] b_reg;
    logic [INWD-1:0] cnt_p;
    logic            c_q;
    logic            gt_p;

    assign gt_p   = b_reg > bitrev(cnt_p);
    assign oC[ch] = c_q;

    if (BIPOLAR != 0) begin : g_bi
      logic [INWD-1:0] cnt_n;
      logic            gt_n;

      assign gt_n = b_reg > bitrev(cnt_n);

      // XNOR-style product; each input polarity walks its own RNG
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          b_reg <= '0;
          cnt_p <= '0;
          cnt_n <= '0;
          c_q   <= 1'b0;
        end else begin
          c_q <= iA[ch] ? gt_p : ~gt_n;
          if (loadB[ch]) begin
            b_reg <= iB[ch*INWD +: INWD];
            cnt_p <= '0;
            cnt_n <= '0;
          end else if (iA[ch]) begin
            cnt_p <= cnt_p + 1'b1;
          end else begin
            cnt_n <= cnt_n + 1'b1;
          end
        end
      end
    end else begin : g_uni
      // AND-style product; RNG only advances on input ones
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          b_reg <= '0;
          cnt_p <= '0;
          c_q   <= 1'b0;
        end else begin
          c_q <= iA[ch] & gt_p;
          if (loadB[ch]) begin
            b_reg <= iB[ch*INWD +: INWD];
            cnt_p <= '0;
          end else if (iA[ch]) begin
            cnt_p <= cnt_p + 1'b1;
          end
        end
      end
    end

`ifdef UMUL_ACC_EN
    logic [INWD:0] acc_q;
    logic [INWD:0] acc_o;

    assign oAcc[ch*(INWD+1) +: INWD+1] = acc_o;

    // ones count per window, published at the last window edge
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc_q <= '0;
        acc_o <= '0;
      end else if (win_last) begin
        acc_o <= acc_q + (INWD+1)'(c_q);
        acc_q <= '0;
      end else begin
        acc_q <= acc_q + (INWD+1)'(c_q);
      end
    end
`endif
  end

endmodule

// File: tb/tb_umul_nch.sv
// Bench for umul_nch: unipolar and bipolar instances on shared stimulus,
// checked each cycle against an integer reference model.
module tb_umul_nch;
  localparam int INWD = 8;
  localparam int NCH  = 4;
  localparam int P    = 1 << INWD;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NCH-1:0]      ia;
  logic [NCH*INWD-1:0] ib;
  logic [NCH-1:0]      ldb;
  logic [NCH-1:0]      oc_u;
  logic [NCH-1:0]      oc_b;
`ifdef UMUL_ACC_EN
  logic [NCH*(INWD+1)-1:0] acc_u, acc_b;
  logic                    vld_u, vld_b;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  umul_nch #(.INWD(INWD), .NCH(NCH), .BIPOLAR(0)) u_uni (
    .clk(clk), .rst_n(rst_n), .iA(ia), .iB(ib),
    .loadB(ldb), .oC(oc_u)
`ifdef UMUL_ACC_EN
    , .oAcc(acc_u), .oAccVld(vld_u)
`endif
  );

  umul_nch #(.INWD(INWD), .NCH(NCH), .BIPOLAR(1)) u_bip (
    .clk(clk), .rst_n(rst_n), .iA(ia), .iB(ib),
    .loadB(ldb), .oC(oc_b)
`ifdef UMUL_ACC_EN
    , .oAcc(acc_b), .oAccVld(vld_b)
`endif
  );

  task automatic chk(string tag, longint got, longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference model: weights and advance counts as plain integers
  int mb[NCH], mp[NCH], mn[NCH];
  logic [NCH-1:0] eu, eb;
  int win, macc[NCH], moacc[NCH];
  bit mvld;

  function automatic int rev(int v);
    int r = 0;
    for (int i = 0; i < INWD; i++) r = r * 2 + ((v >> i) & 1);
    return r;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      mb[c] = 0; mp[c] = 0; mn[c] = 0;
      macc[c] = 0; moacc[c] = 0;
    end
    eu = '0; eb = '0; win = 0; mvld = 0;
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int c = 0; c < NCH; c++) begin
      if (win == P - 1) begin
        moacc[c] = macc[c] + eu[c];
        macc[c] = 0;
      end else begin
        macc[c] += eu[c];
      end
    end
    mvld = (win == P - 1);
    win = (win + 1) % P;
    for (int c = 0; c < NCH; c++) begin
      bit gp, gn;
      gp = mb[c] > rev(mp[c]);
      gn = mb[c] > rev(mn[c]);
      eu[c] = ia[c] && gp;
      eb[c] = ia[c] ? gp : !gn;
      if (ldb[c]) begin
        mb[c] = int'(ib[c*INWD +: INWD]);
        mp[c] = 0; mn[c] = 0;
      end else if (ia[c]) begin
        mp[c] = (mp[c] + 1) % P;
      end else begin
        mn[c] = (mn[c] + 1) % P;
      end
    end
  endtask

  task automatic compare();
    chk("oc_uni", oc_u, eu);
    chk("oc_bip", oc_b, eb);
`ifdef UMUL_ACC_EN
    chk("vld", vld_u, mvld);
    for (int c = 0; c < NCH; c++)
      chk("oacc", acc_u[c*(INWD+1) +: INWD+1], moacc[c]);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic load0(int b);
    ia = '0;
    ldb = 4'b0001;
    ib = $urandom;
    ib[INWD-1:0] = INWD'(b);
    tick();
    ldb = '0;
  endtask

  int ones_u, ones_b, bad;
  bit first_u, last_u;

  task automatic run0(int n, bit gap);
    ones_u = 0; ones_b = 0; bad = 0;
    for (int i = 0; i < n; i++) begin
      ia = NCH'($urandom);
      ia[0] = gap ? ((i % 2) == 0) : 1'b1;
      ib = $urandom;
      tick();
      if (i == 0) first_u = oc_u[0];
      if (i == n - 1) last_u = oc_u[0];
      ones_u += oc_u[0];
      ones_b += oc_b[0];
      if (gap && (i % 2) == 1 && oc_u[0]) bad++;
    end
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    ia = '0; ib = '0; ldb = '0;
    for (int i = 0; i < 5; i++) begin
      ia = NCH'($urandom); ib = $urandom; ldb = NCH'($urandom);
      tick();
      chk("rst_oc_u", oc_u, 0);
    end
    ia = '0; ldb = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_oc", oc_u, 0);
    end

    load0(128);
    run0(P, 0);
    chk("b128_first", first_u, 1);
    chk("b128_ones", ones_u, 128);
    chk("b128_bip_ones", ones_b, 128);

    load0(64);
    run0(2 * P, 1);
    chk("gap_ones", ones_u, 64);
    chk("gap_zero", bad, 0);

    load0(0);
    run0(P, 0);
    chk("b0_ones", ones_u, 0);

    load0(255);
    run0(P, 0);
    chk("b255_ones", ones_u, 255);
    chk("b255_last", last_u, 0);

    load0(255);
    ones_b = 0;
    for (int i = 0; i < P; i++) begin
      ia = NCH'($urandom); ia[0] = 1'b0;
      tick();
      ones_b += oc_b[0];
    end
    chk("bip_b255_neg", ones_b, 1);

    for (int i = 0; i < 2000; i++) begin
      ia = NCH'($urandom);
      ib = $urandom;
      ldb = '0;
      for (int c = 0; c < NCH; c++)
        ldb[c] = ($urandom_range(15) == 0);
      if (i == 700) begin
        ldb = 4'b0010; ia[1] = 1'b1;
      end
      tick();
    end
    ldb = '0;

    ia = '1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_rst_u", oc_u, 0);
    chk("async_rst_b", oc_b, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    load0(128);
    run0(3 * P, 0);
    chk("restart_ones", ones_u, 384);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
